// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and code-to-segment decode for the signed
// 7-segment display path.
package seg7_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_e;

  typedef enum logic [3:0] {
    CODE_0     = 4'd0,
    CODE_1     = 4'd1,
    CODE_2     = 4'd2,
    CODE_3     = 4'd3,
    CODE_4     = 4'd4,
    CODE_5     = 4'd5,
    CODE_6     = 4'd6,
    CODE_7     = 4'd7,
    CODE_8     = 4'd8,
    CODE_9     = 4'd9,
    CODE_MINUS = 4'd10,
    CODE_O     = 4'd11,
    CODE_F     = 4'd12,
    CODE_L     = 4'd13,
    CODE_BLANK = 4'd15
  } disp_code_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] code_to_seg(input disp_code_e code);
    logic [6:0] s;
    case (code)
      CODE_0, CODE_O: s = SEG_0;
      CODE_1:         s = SEG_1;
      CODE_2:         s = SEG_2;
      CODE_3:         s = SEG_3;
      CODE_4:         s = SEG_4;
      CODE_5:         s = SEG_5;
      CODE_6:         s = SEG_6;
      CODE_7:         s = SEG_7;
      CODE_8:         s = SEG_8;
      CODE_9:         s = SEG_9;
      CODE_MINUS:     s = SEG_MINUS;
      CODE_F:         s = SEG_F;
      CODE_L:         s = SEG_L;
      default:        s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd8_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit
// per clock).
//
//   state   | meaning
//   IDLE    | waiting for start; busy low
//   CONVERT | shifting magnitude bits in, 8 cycles; busy high
module bin2bcd8_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mag,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done
);

  conv_state_e state_q, state_d;
  logic [2:0]  cnt_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;
  logic        last_iter;

  assign last_iter = (state_q == CONVERT) && (cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONVERT);
    done = last_iter;
  end

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[10:0], bin_q[7]};
  end

  // The result is taken straight from the final shift so the parent can
  // commit it on the same edge that busy falls.
  assign hundreds = bcd_shift[11:8];
  assign tens     = bcd_shift[7:4];
  assign ones     = bcd_shift[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      bin_q <= 8'd0;
      bcd_q <= 12'd0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cnt_q <= 3'd0;
        bin_q <= mag;
        bcd_q <= 12'd0;
      end
    end else begin
      cnt_q <= cnt_q + 3'd1;
      bin_q <= {bin_q[6:0], 1'b0};
      bcd_q <= bcd_shift;
    end
  end

endmodule

// File: rtl/seg7_signed_display.sv
// Captures a signed adder result, converts it to sign + BCD magnitude and
// scans it onto a 4-digit common-anode 7-segment display.
module seg7_signed_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] S_in,
  input  logic       ovfl_in,
  input  logic       load,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic       start;
  logic [7:0] mag;
  logic       neg_cap, ovfl_cap;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  logic       conv_done;

  logic       disp_neg, disp_ovfl;
  logic [3:0] disp_h, disp_t, disp_o;
  logic       nxt_neg, nxt_ovfl;
  logic [3:0] nxt_h, nxt_t, nxt_o;

  logic [RW-1:0] refresh_q;
  logic [1:0]    idx_q;
  disp_code_e    code;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  assign start = load && !busy;
  assign mag   = S_in[7] ? (~S_in + 8'd1) : S_in;

  bin2bcd8_seq u_bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mag      (mag),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o),
    .busy     (busy),
    .done     (conv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cap  <= 1'b0;
      ovfl_cap <= 1'b0;
    end else if (start) begin
      neg_cap  <= S_in[7];
      ovfl_cap <= ovfl_in;
    end
  end

  always_comb begin
    nxt_neg  = conv_done ? neg_cap  : disp_neg;
    nxt_ovfl = conv_done ? ovfl_cap : disp_ovfl;
    nxt_h    = conv_done ? bcd_h    : disp_h;
    nxt_t    = conv_done ? bcd_t    : disp_t;
    nxt_o    = conv_done ? bcd_o    : disp_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_neg  <= 1'b0;
      disp_ovfl <= 1'b0;
      disp_h    <= 4'd0;
      disp_t    <= 4'd0;
      disp_o    <= 4'd0;
    end else begin
      disp_neg  <= nxt_neg;
      disp_ovfl <= nxt_ovfl;
      disp_h    <= nxt_h;
      disp_t    <= nxt_t;
      disp_o    <= nxt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + RW'(1);
    end
  end

  // Selection reads the next-committed value so a commit shows up on seg at
  // the same edge busy falls.
  always_comb begin
    code = CODE_BLANK;
    if (nxt_ovfl) begin
      case (idx_q)
        2'd2:    code = CODE_O;
        2'd1:    code = CODE_F;
        2'd0:    code = CODE_L;
        default: code = CODE_BLANK;
      endcase
    end else begin
      case (idx_q)
        2'd3:    code = nxt_neg ? CODE_MINUS : CODE_BLANK;
        2'd2:    code = (nxt_h != 4'd0) ? disp_code_e'(nxt_h) : CODE_BLANK;
        2'd1:    code = ((nxt_h != 4'd0) || (nxt_t != 4'd0)) ? disp_code_e'(nxt_t) : CODE_BLANK;
        default: code = disp_code_e'(nxt_o);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= code_to_seg(code);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: doc/seg7_signed_display.md
Name: seg7_signed_display

Overview:
- Downstream consumer of the 8-bit adder/sign-changer result: S[7:0] (two's complement) and ovfl.
- Captures a result on a load strobe and converts it to sign + magnitude.
- Runs a sequential double-dabble BCD conversion, then drives a 4-digit time-multiplexed common-anode 7-segment display.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit before the scan advances; legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- S_in  input  8  signed two's-complement result from the adder stage.
- ovfl_in  input  1  adder overflow flag, captured with S_in.
- load  input  1  capture strobe; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit enables, active-low, one-hot-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, clears all state):
  - an=4'b1111, seg=7'b1111111, busy=0, FSM=IDLE.
  - Committed display value = 0, no sign, no ovfl.
  - Scan index = 0, refresh counter = 0.
- FSM states and transitions:
  - IDLE: on a clk edge with load=1, capture S_in and ovfl_in, go to CONVERT, busy=1.
  - CONVERT: 8 iterations, one per clock; each iteration applies add-3 (BCD digit >= 5) and then shifts one magnitude bit in, MSB first.
  - After the 8th iteration: commit sign, hundreds, tens, ones and ovfl to the display registers atomically, return to IDLE, busy=0.
  - busy is high for exactly 8 cycles. A new value is visible from the edge on which busy falls.
- Magnitude rule: mag = S_in[7] ? (~S_in + 1) : S_in, computed as unsigned 8-bit. 8'h80 gives 128.
- load while busy is ignored. It neither restarts nor queues a conversion.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At wrap, the digit index advances 0→1→2→3→0.
  - The scan is free-running, is unaffected by load/commit, and keeps showing the old committed value during CONVERT.
  - an = ~(4'b0001 << index), driven from registers.
  - seg is registered and changes on the same edge as an.
- Digit content when ovfl=0:
  - digit3: '-' if negative, else blank.
  - digit2: hundreds, blank if 0.
  - digit1: tens, blank if hundreds and tens are both 0.
  - digit0: ones, always shown.
- Digit content when ovfl=1: digit3 blank, digit2 'O', digit1 'F', digit0 'L'.
- Segment codes (active-low, {g..a}):
  - '0'/'O'=1000000, '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001.
  - '5'=0010010, '6'=0000010, '7'=1111000, '8'=0000000, '9'=0010000.
  - '-'=0111111, 'F'=0001110, 'L'=1000111, blank=1111111.
- Reset mid-CONVERT: abandon the conversion, no commit, outputs take reset values.
- After reset release: first lit digit is digit0 showing '0'.

Decomposition:
- Package seg7_pkg holds:
  - FSM state enum (IDLE, CONVERT).
  - 4-bit display-code typedef covering digits 0-9 plus MINUS, O, F, L, BLANK.
  - Segment-pattern constants.
  - A pure decode function from code to seg.
- Sub-module bin2bcd8_seq owns the conversion FSM, the 8-iteration shift/add-3 datapath, busy and the done pulse.
  - Inputs: clk, rst_n, start, 8-bit mag.
  - Outputs: 4-bit BCD hundreds/tens/ones digits, busy, 1-cycle done pulse.
- Top level owns capture, sign/magnitude, the commit registers, digit selection and the scan.

Test Plan:
- Reset with REFRESH_DIV=4: all outputs at reset values during reset. After release, an sequence 1110,1101,1011,0111,1110, each held 4 cycles. seg is 1000000 on an=1110 and 1111111 on the other digits.
- load with S_in=8'h7F, ovfl_in=0: busy high exactly 8 cycles. Then digits 3..0 = blank,'1','2','7'; seg on an=1101 is 0100100.
- load with S_in=8'h80: digits '-','1','2','8'. load with S_in=8'hFB: digits '-',blank,blank,'5', with seg=0010010 on an=1110.
- load with S_in=8'h05, ovfl_in=1: digits blank,'O','F','L' (1000000, 0001110, 1000111).
- load S_in=8'h0C, then load S_in=8'h63 on cycle 3 of busy: the second load is ignored, busy falls after 8 cycles, display shows blank,blank,'1','2'.
- load S_in=8'h63, then assert rst_n=0 at busy cycle 4: busy=0 and an=1111 immediately. After release, digit0 shows '0' and no '9'/'6' appears.
